// File: rtl/seg7_mon_pkg.sv
// seg7_mon_pkg: shared segment pattern constants and monitor state type.
//  Patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_mon_pkg;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   typedef enum logic {UNLOCKED, LOCKED} state_t;
endpackage

// File: rtl/seg7_monitor_decode.sv
// seg7_decode: combinational 7-segment pattern to digit decoder.
//  seg   in  7  pattern {g,f,e,d,c,b,a}
//  legal out 1  pattern is one of the digits 0..9
//  blank out 1  pattern is all segments off
//  digit out 4  decoded digit (4'hF when not legal)
module seg7_decode
   import seg7_mon_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic       blank,
   output logic [3:0] digit
);
   always_comb begin
      digit = seg == SEG_0 ? 4'd0 :
              seg == SEG_1 ? 4'd1 :
              seg == SEG_2 ? 4'd2 :
              seg == SEG_3 ? 4'd3 :
              seg == SEG_4 ? 4'd4 :
              seg == SEG_5 ? 4'd5 :
              seg == SEG_6 ? 4'd6 :
              seg == SEG_7 ? 4'd7 :
              seg == SEG_8 ? 4'd8 :
              seg == SEG_9 ? 4'd9 : 4'hF;
      legal = digit != 4'hF;
      blank = seg == SEG_BLANK;
   end
endmodule

// File: rtl/seg7_monitor.sv
// seg7_monitor: display-side checker that filters, decodes and sequence/period-checks a 7-segment digit stream.
//  clk, reset (sync, active-high); seg_in[6:0] raw segments, may be asynchronous.
//  digit/digit_valid: last accepted digit; digit_strobe: new pattern accepted; locked: FSM in LOCKED.
//  seq_err/decode_err/period_err: one-cycle error pulses; period/period_valid: last interval measured while locked.
//  err_count: saturating count of strobes carrying any error.
//  Optional macro SEG7_MON_PERIOD_CHECK_EN enables the period tolerance check; otherwise period_err is tied 0.
module seg7_monitor
   import seg7_mon_pkg::*;
#(
   parameter int                   STABLE_CYCLES   = 4,
   parameter int                   PERIOD_W        = 24,
   parameter int                   ERR_W           = 8,
   parameter logic [PERIOD_W-1:0]  EXPECTED_PERIOD = 24'd10000001,
   parameter logic [PERIOD_W-1:0]  PERIOD_TOL      = 24'd16
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          seg_in,
   output logic [3:0]          digit,
   output logic                digit_valid,
   output logic                digit_strobe,
   output logic                locked,
   output logic                seq_err,
   output logic                decode_err,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                period_err,
   output logic [ERR_W-1:0]    err_count
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   logic [6:0]          s1, s2, cand, accepted;
   logic [SW-1:0]       stab;
   logic [PERIOD_W-1:0] cnt;
   state_t              state;
   logic                legal, blank, accept, capture, seq_bad, dec_bad, per_bad, any_err;
   logic [3:0]          dec, next_digit;
   seg7_decode u_decode (.seg(cand), .legal(legal), .blank(blank), .digit(dec));
   always_comb begin
      accept     = stab == STAB_MAX && cand != accepted;
      next_digit = digit == 4'd9 ? 4'd0 : digit + 4'd1;
      // Only digits arriving while already locked are sequence- and period-checked.
      capture    = accept && legal && state == LOCKED;
      seq_bad    = capture && dec != next_digit;
      dec_bad    = accept && !legal && !blank;
`ifdef SEG7_MON_PERIOD_CHECK_EN
      per_bad    = capture && (&cnt || (cnt > EXPECTED_PERIOD ? cnt - EXPECTED_PERIOD : EXPECTED_PERIOD - cnt) > PERIOD_TOL);
`else
      per_bad    = 1'b0;
`endif
      any_err    = seq_bad || dec_bad || per_bad;
   end
   assign locked = state == LOCKED;
   always_ff @(posedge clk) begin
      if (reset) begin
         s1           <= '0;
         s2           <= '0;
         cand         <= '0;
         stab         <= '0;
         accepted     <= SEG_BLANK;
         cnt          <= '0;
         state        <= UNLOCKED;
         digit        <= '0;
         digit_valid  <= 1'b0;
         digit_strobe <= 1'b0;
         seq_err      <= 1'b0;
         decode_err   <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         err_count    <= '0;
      end else begin
         s1           <= seg_in;
         s2           <= s1;
         cand         <= s2;
         stab         <= s2 != cand ? SW'(1) : stab == STAB_MAX ? stab : stab + SW'(1);
         cnt          <= accept ? PERIOD_W'(1) : &cnt ? cnt : cnt + PERIOD_W'(1);
         digit_strobe <= accept;
         seq_err      <= seq_bad;
         decode_err   <= dec_bad;
         if (accept) begin
            accepted <= cand;
            if (legal) begin
               digit       <= dec;
               digit_valid <= 1'b1;
               state       <= LOCKED;
            end else begin
               digit_valid <= 1'b0;
               state       <= UNLOCKED;
            end
            if (any_err && !(&err_count))
               err_count <= err_count + ERR_W'(1);
         end
         if (capture) begin
            period       <= cnt;
            period_valid <= 1'b1;
         end
      end
   end
`ifdef SEG7_MON_PERIOD_CHECK_EN
   logic period_err_q;
   always_ff @(posedge clk)
      period_err_q <= reset ? 1'b0 : per_bad;
   assign period_err = period_err_q;
`else
   assign period_err = 1'b0;
`endif
endmodule
